// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM command path: opcodes, FSM encoding,
// frame layout and the TX hold length used by the SPI slave.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // One load cycle plus eight shift cycles on the slave side
    localparam int unsigned TX_CYC_DEF = 9;

    localparam int unsigned TMR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_TX       = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] payload;
    } frame_t;

endpackage

// File: rtl/spi_ram_cmd_tmr.sv
// Loadable down-counter; stops at zero. Shared by the read-latency wait and
// the TX hold window.
module spi_ram_cmd_tmr
    import spi_ram_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    output logic             zero_c
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/spi_ram_cmd_ctrl.sv
// Command sequencer between the SPI slave and the single-port RAM side:
// frame decode, address registers, RAM strobes and read-data return.
module spi_ram_cmd_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned TX_CYC   = TX_CYC_DEF,
    parameter int unsigned AUTO_INC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [9:0]        rx_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              cmd_err
);

    state_t            state;
    frame_t            frame_c;
    logic              rx_d;
    logic              rise_c;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_vld;
    logic              rd_vld;
    logic              tmr_load_c;
    logic [TMR_W-1:0]  tmr_val_c;
    logic              tmr_zero_c;

    assign frame_c = frame_t'(rx_data);
    assign rise_c  = rx_valid & ~rx_d;

    // Counts are loaded one short so the zero cycle is the last cycle of each window
    assign tmr_load_c = (state == ST_RD_ISSUE) || ((state == ST_RD_WAIT) && tmr_zero_c);
    assign tmr_val_c  = (state == ST_RD_ISSUE) ? TMR_W'(RD_LAT - 1) : TMR_W'(TX_CYC - 1);

    spi_ram_cmd_tmr u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load_c),
        .value  (tmr_val_c),
        .zero_c (tmr_zero_c)
    );

    // Edge detect, decode, FSM and address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rx_d     <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_vld   <= 1'b0;
            rd_vld   <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            busy     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            rx_d    <= rx_valid;
            ram_we  <= 1'b0;
            ram_re  <= 1'b0;
            cmd_err <= 1'b0;

            if (rise_c && (state != ST_IDLE)) begin
                cmd_err <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (rise_c) begin
                        case (frame_c.op)
                            OP_WR_ADDR: begin
                                wr_addr  <= frame_c.payload[ADDR_W-1:0];
                                wr_vld   <= 1'b1;
                                ram_addr <= frame_c.payload[ADDR_W-1:0];
                            end
                            OP_RD_ADDR: begin
                                rd_addr <= frame_c.payload[ADDR_W-1:0];
                                rd_vld  <= 1'b1;
                            end
                            OP_WR_DATA: begin
                                if (wr_vld) begin
                                    state   <= ST_WRITE;
                                    busy    <= 1'b1;
                                    ram_we  <= 1'b1;
                                    ram_din <= frame_c.payload;
                                end else begin
                                    cmd_err <= 1'b1;
                                end
                            end
                            OP_RD_DATA: begin
                                if (rd_vld) begin
                                    state    <= ST_RD_ISSUE;
                                    busy     <= 1'b1;
                                    ram_re   <= 1'b1;
                                    ram_addr <= rd_addr;
                                end else begin
                                    cmd_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (AUTO_INC != 0) begin
                        wr_addr  <= wr_addr + ADDR_W'(1);
                        ram_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                ST_RD_ISSUE: begin
                    state    <= ST_RD_WAIT;
                    ram_addr <= wr_addr;
                end
                ST_RD_WAIT: begin
                    if (tmr_zero_c) begin
                        state    <= ST_TX;
                        tx_data  <= ram_dout;
                        tx_valid <= 1'b1;
                        if (AUTO_INC != 0) begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_TX: begin
                    if (tmr_zero_c) begin
                        state    <= ST_IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_cmd_ctrl.sv
// Directed bench for spi_ram_cmd_ctrl: one instance without and one with
// address auto-increment, each backed by a 1-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_spi_ram_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data = '0;

    logic       tx_valid0, ram_we0, ram_re0, busy0, cmd_err0;
    logic [7:0] tx_data0, ram_addr0, ram_din0;
    logic [7:0] ram_dout0 = '0;
    logic       tx_valid1, ram_we1, ram_re1, busy1, cmd_err1;
    logic [7:0] tx_data1, ram_addr1, ram_din1;
    logic [7:0] ram_dout1 = '0;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_ram_cmd_ctrl #(.AUTO_INC(0)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid0), .tx_data(tx_data0), .ram_addr(ram_addr0),
        .ram_din(ram_din0), .ram_we(ram_we0), .ram_re(ram_re0),
        .ram_dout(ram_dout0), .busy(busy0), .cmd_err(cmd_err0)
    );

    spi_ram_cmd_ctrl #(.AUTO_INC(1)) dut_ai (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid1), .tx_data(tx_data1), .ram_addr(ram_addr1),
        .ram_din(ram_din1), .ram_we(ram_we1), .ram_re(ram_re1),
        .ram_dout(ram_dout1), .busy(busy1), .cmd_err(cmd_err1)
    );

    // Synchronous RAM models, read latency 1
    always @(posedge clk) begin
        if (ram_we0) mem0[ram_addr0] <= ram_din0;
        if (ram_re0) ram_dout0 <= mem0[ram_addr0];
        if (ram_we1) mem1[ram_addr1] <= ram_din1;
        if (ram_re1) ram_dout1 <= mem1[ram_addr1];
    end

    int         cyc = 0;
    int         we_cnt = 0, re_cnt = 0, err_cnt = 0, both_hi = 0;
    int         re_cyc = 0, tx_first = 0, tx_len = 0, tx_unstable = 0;
    logic       tx_prev = 1'b0;
    logic [7:0] we_addr = '0, we_din = '0, tx_first_val = '0;
    logic [7:0] we_log1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we0) begin
            we_cnt  = we_cnt + 1;
            we_addr = ram_addr0;
            we_din  = ram_din0;
        end
        if (ram_re0) begin
            re_cnt = re_cnt + 1;
            re_cyc = cyc;
        end
        if (cmd_err0) err_cnt = err_cnt + 1;
        if (ram_we0 && ram_re0) both_hi = both_hi + 1;
        if (tx_valid0) begin
            if (!tx_prev) begin
                tx_first     = cyc;
                tx_len       = 1;
                tx_first_val = tx_data0;
            end else begin
                tx_len = tx_len + 1;
                if (tx_data0 !== tx_first_val) tx_unstable = tx_unstable + 1;
            end
        end
        tx_prev = tx_valid0;
        if (ram_we1) we_log1.push_back(ram_addr1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Frame held high for three cycles, then low for one
    task automatic send(input logic [1:0] op, input logic [7:0] pl);
        @(negedge clk);
        rx_data  = {op, pl};
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy0 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int e0, w0, r0, n;

        // Reset and idle
        do_reset();
        check("reset_outputs", 32'({tx_valid0, tx_data0, ram_addr0, ram_din0,
                                    ram_we0, ram_re0, busy0, cmd_err0}), 32'd0);
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy0), 32'd0);
        check("idle_no_we", 32'(we_cnt), 32'd0);

        // Write 0xA5 to 0x12
        send(2'b00, 8'h12);
        send(2'b01, 8'hA5);
        check("wr_count", 32'(we_cnt), 32'd1);
        check("wr_addr", 32'(we_addr), 32'h12);
        check("wr_din", 32'(we_din), 32'hA5);
        check("wr_no_err", 32'(err_cnt), 32'd0);
        check("idle_ram_addr", 32'(ram_addr0), 32'h12);

        // Read back 0x12
        send(2'b10, 8'h12);
        send(2'b11, 8'h00);
        wait_idle("rd_done");
        check("rd_count", 32'(re_cnt), 32'd1);
        check("rd_to_tx_lat", 32'(tx_first - re_cyc), 32'd2);
        check("tx_len", 32'(tx_len), 32'd9);
        check("tx_data", 32'(tx_first_val), 32'hA5);
        check("tx_stable", 32'(tx_unstable), 32'd0);
        check("tx_valid_low", 32'(tx_valid0), 32'd0);
        check("tx_data_kept", 32'(tx_data0), 32'hA5);
        check("held_rx_no_err", 32'(err_cnt), 32'd0);

        // Data commands without a loaded address
        do_reset();
        e0 = err_cnt; w0 = we_cnt;
        send(2'b01, 8'h33);
        check("err_wr_pulse", 32'(err_cnt - e0), 32'd1);
        check("err_wr_no_we", 32'(we_cnt - w0), 32'd0);
        do_reset();
        e0 = err_cnt; r0 = re_cnt;
        send(2'b11, 8'h00);
        check("err_rd_pulse", 32'(err_cnt - e0), 32'd1);
        check("err_rd_no_re", 32'(re_cnt - r0), 32'd0);

        // Auto-increment wrap on writes and reads
        do_reset();
        we_log1.delete();
        send(2'b00, 8'hFF);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        send(2'b01, 8'h33);
        check("ai_wr_n", 32'(we_log1.size()), 32'd3);
        if (we_log1.size() == 3) begin
            check("ai_wr0", 32'(we_log1[0]), 32'hFF);
            check("ai_wr1", 32'(we_log1[1]), 32'h00);
            check("ai_wr2", 32'(we_log1[2]), 32'h01);
        end
        e0 = err_cnt;
        send(2'b10, 8'hFF);
        send(2'b11, 8'h00);
        wait_idle("ai_rd0_done");
        check("ai_rd0", 32'(tx_data1), 32'h11);
        send(2'b11, 8'h00);
        wait_idle("ai_rd1_done");
        check("ai_rd1", 32'(tx_data1), 32'h22);
        send(2'b11, 8'h00);
        wait_idle("ai_rd2_done");
        check("ai_rd2", 32'(tx_data1), 32'h33);
        check("noinc_rd", 32'(tx_data0), 32'h33);
        check("b2b_no_err", 32'(err_cnt - e0), 32'd0);
        check("no_we_re_overlap", 32'(both_hi), 32'd0);

        // Command during TX is dropped
        send(2'b00, 8'h40);
        send(2'b10, 8'hFF);
        e0 = err_cnt;
        send(2'b11, 8'h00);
        check("in_tx", 32'(tx_valid0), 32'd1);
        send(2'b00, 8'h77);
        wait_idle("busy_drop_done");
        check("busy_drop_err", 32'(err_cnt - e0), 32'd1);
        check("busy_drop_addr", 32'(ram_addr0), 32'h40);

        // Reset in the middle of TX
        send(2'b11, 8'h00);
        n = 0;
        while (!tx_valid0 && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        check("tx_before_rst", 32'(tx_valid0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_tx_valid", 32'(tx_valid0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_strobes", 32'({ram_we0, ram_re0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e0 = err_cnt; r0 = re_cnt; w0 = we_cnt;
        send(2'b11, 8'h00);
        check("post_rst_rd_err", 32'(err_cnt - e0), 32'd1);
        check("post_rst_no_re", 32'(re_cnt - r0), 32'd0);
        send(2'b01, 8'h05);
        check("post_rst_wr_err", 32'(err_cnt - e0), 32'd2);
        check("post_rst_no_we", 32'(we_cnt - w0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
